// File: rtl/apple_spawner.sv
// apple_spawner
//   Owns the apple for the snake game. Holds the committed apple cell, picks
//   a fresh free cell after the apple is eaten, and renders the apple for the
//   colour-priority mux.
//
//   Candidate cells come from a free-running 16-bit Galois LFSR. Each
//   candidate is checked against the snake body over a query handshake. After
//   MAX_TRIES failed attempts the picker stops drawing random cells. It then
//   walks the interior in raster order, so a nearly full grid still ends up
//   with an apple.
//   A new position only becomes visible at frame_tick, so a frame never
//   shows a torn apple.
//
//   Optional feature: define APPLE_BLINK_EN to make a fresh apple blink
//   (8 frames on / 8 frames off) for its first 48 frames.
//
// Ports
//   clk          in   pixel clock, single clock domain
//   reset        in   synchronous, active-high
//   frame_tick   in   one-cycle pulse at start of vertical blank
//   eaten        in   one-cycle pulse: snake head entered the apple cell
//   x, y         in   current pixel column / row
//   query_valid  out  candidate cell presented to the snake block
//   query_x/y    out  candidate cell column / row
//   query_ready  in   snake block answer strobe
//   query_hit    in   candidate overlaps snake (valid with query_ready)
//   apple_valid  out  apple present on screen
//   apple_x/y    out  committed apple column / row
//   apples_eaten out  saturating count of accepted eaten pulses
//   active_apple out  current pixel lies inside the apple cell
//   rgb_apple    out  apple colour
module apple_spawner #(
    parameter int          GRID_W     = 40,
    parameter int          GRID_H     = 30,
    parameter int          CELL_SHIFT = 4,
    parameter int          MAX_TRIES  = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       eaten,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       query_valid,
    output logic [5:0] query_x,
    output logic [4:0] query_y,
    input  logic       query_ready,
    input  logic       query_hit,
    output logic       apple_valid,
    output logic [5:0] apple_x,
    output logic [4:0] apple_y,
    output logic [7:0] apples_eaten,
    output logic       active_apple,
    output logic [2:0] rgb_apple
);

    localparam int            TW        = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);
    localparam logic [5:0]    X_MAX     = 6'(GRID_W - 2);
    localparam logic [4:0]    Y_MAX     = 5'(GRID_H - 2);

    typedef enum logic [1:0] {
        PICK       = 2'd0,
        QUERY      = 2'd1,
        WAIT_FRAME = 2'd2,
        SHOW       = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [15:0]   lfsr, lfsr_next;
    logic [TW-1:0] tries;
    logic [5:0]    cand_x, next_cand_x, rand_x, seq_x;
    logic [4:0]    cand_y, next_cand_y, rand_y, seq_y;
    logic          rand_ok, random_mode;
    logic          load_cand, tries_inc, commit, eat;
    logic          in_cell, show_gate;

    // Galois form, taps 16,14,13,11: the bit shifted out is fed back into
    // bits 15,13,12,10.
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    assign rand_x      = lfsr[5:0];
    assign rand_y      = lfsr[12:8];
    assign rand_ok     = (rand_x >= 6'd1) && (rand_x <= X_MAX) &&
                         (rand_y >= 5'd1) && (rand_y <= Y_MAX);
    assign random_mode = (tries < TRIES_MAX);

    // Raster successor of the last candidate over the interior. An
    // out-of-range starting point, such as (0,0) after reset, lands on (1,1)
    // or the start of the next row.
    always_comb begin
        seq_x = 6'd1;
        seq_y = 5'd1;
        if (cand_x >= X_MAX) begin
            seq_x = 6'd1;
            if ((cand_y >= Y_MAX) || (cand_y == 5'd0)) begin
                seq_y = 5'd1;
            end else begin
                seq_y = cand_y + 5'd1;
            end
        end else begin
            seq_x = cand_x + 6'd1;
            if ((cand_y == 5'd0) || (cand_y > Y_MAX)) begin
                seq_y = 5'd1;
            end else begin
                seq_y = cand_y;
            end
        end
    end

    // Next-state logic. The registered side only acts on the strobes set here.
    always_comb begin
        state_next  = state;
        load_cand   = 1'b0;
        next_cand_x = cand_x;
        next_cand_y = cand_y;
        tries_inc   = 1'b0;
        commit      = 1'b0;
        eat         = 1'b0;
        case (state)
            PICK: begin
                if (random_mode) begin
                    if (rand_ok) begin
                        load_cand   = 1'b1;
                        next_cand_x = rand_x;
                        next_cand_y = rand_y;
                        state_next  = QUERY;
                    end else begin
                        tries_inc = 1'b1;
                    end
                end else begin
                    load_cand   = 1'b1;
                    next_cand_x = seq_x;
                    next_cand_y = seq_y;
                    state_next  = QUERY;
                end
            end
            QUERY: begin
                if (query_ready) begin
                    if (query_hit) begin
                        tries_inc  = 1'b1;
                        state_next = PICK;
                    end else begin
                        state_next = WAIT_FRAME;
                    end
                end
            end
            WAIT_FRAME: begin
                if (frame_tick) begin
                    commit     = 1'b1;
                    state_next = SHOW;
                end
            end
            SHOW: begin
                // eaten takes precedence over a simultaneous frame_tick
                if (eaten) begin
                    eat        = 1'b1;
                    state_next = PICK;
                end
            end
            default: state_next = PICK;
        endcase
    end

    // State, LFSR and apple registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= PICK;
            lfsr         <= LFSR_SEED;
            tries        <= '0;
            cand_x       <= '0;
            cand_y       <= '0;
            apple_valid  <= 1'b0;
            apple_x      <= '0;
            apple_y      <= '0;
            apples_eaten <= '0;
        end else begin
            state <= state_next;
            lfsr  <= lfsr_next;
            if (load_cand) begin
                cand_x <= next_cand_x;
                cand_y <= next_cand_y;
            end
            if (commit) begin
                apple_valid <= 1'b1;
                apple_x     <= cand_x;
                apple_y     <= cand_y;
                tries       <= '0;
            end else if (tries_inc && (tries < TRIES_MAX)) begin
                tries <= tries + 1'b1;
            end
            if (eat) begin
                apple_valid <= 1'b0;
                if (apples_eaten != 8'hFF) begin
                    apples_eaten <= apples_eaten + 8'd1;
                end
            end
        end
    end

`ifdef APPLE_BLINK_EN
    logic [5:0] blink_cnt;

    // Counts the frames the current apple has been on screen. The count
    // restarts at each spawn and holds at 63.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= '0;
        end else if (commit) begin
            blink_cnt <= '0;
        end else if ((state == SHOW) && frame_tick && (blink_cnt != 6'd63)) begin
            blink_cnt <= blink_cnt + 6'd1;
        end
    end

    assign show_gate = (blink_cnt >= 6'd48) || !blink_cnt[3];
`else
    assign show_gate = 1'b1;
`endif

    assign in_cell = apple_valid &&
                     ((x >> CELL_SHIFT) == 10'(apple_x)) &&
                     ((y >> CELL_SHIFT) == 10'(apple_y));

    assign active_apple = in_cell && show_gate;
    assign rgb_apple    = 3'b100;
    assign query_valid  = (state == QUERY);
    assign query_x      = cand_x;
    assign query_y      = cand_y;

endmodule
